// File: rtl/hamming_encoder_tx_if.sv
// Word-request handshake between a producer and the Hamming(15,11) serial transmitter.
// err_pos travels with data_in so a test fault can be injected into a single frame.
interface hamming_encoder_tx_if;
  logic        valid;
  logic        ready;
  logic [10:0] data_in;
  logic [3:0]  err_pos;

  modport master (output valid, output data_in, output err_pos, input ready);
  modport slave  (input valid, input data_in, input err_pos, output ready);
endinterface

// File: rtl/hamming_encoder_tx.sv
// Hamming(15,11) even-parity encoder with a serial MSB-first transmitter.
// The line sits at IDLE_LEVEL outside frames, and FRAME_GAP idle cycles follow each frame.
module hamming_encoder_tx #(
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned FRAME_GAP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       device_en,
  hamming_encoder_tx_if.slave        bus,
  output logic                       serial_out,
  output logic                       tx_active,
  output logic                       frame_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_reg;
  logic [14:0] shift_reg;
  logic [3:0]  bit_cnt_reg;
  logic [1:0]  gap_cnt_reg;
  logic        ready_ok_reg;
  logic        tx_active_reg;
  logic        frame_done_reg;

  logic [14:0] data_word;
  logic [3:0]  parity_bits;
  logic [14:0] code_word;
  logic        ready;
  logic        transfer;

  // Codeword position (1..15) that carries data bit i.
  function automatic int data_pos(input int i);
    if (i == 0)
      return 3;
    else if (i < 4)
      return i + 4;
    else
      return i + 5;
  endfunction

  // Every codeword position whose index has bit k set.
  function automatic logic [14:0] parity_mask(input int k);
    logic [14:0] m;
    m = '0;
    for (int p = 1; p < 16; p++) begin
      if (p[k])
        m[p-1] = 1'b1;
    end
    return m;
  endfunction

  always_comb begin
    data_word = '0;
    for (int i = 0; i < 11; i++)
      data_word[data_pos(i)-1] = bus.data_in[i];
  end

  // Parity positions are zero in data_word, so the mask may include them harmlessly.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_parity
      assign parity_bits[gi] = ^(data_word & parity_mask(gi));
    end
  endgenerate

  always_comb begin
    code_word     = data_word;
    code_word[0]  = parity_bits[0];
    code_word[1]  = parity_bits[1];
    code_word[3]  = parity_bits[2];
    code_word[7]  = parity_bits[3];
    if (bus.err_pos != 4'd0)
      code_word[bus.err_pos - 4'd1] = ~code_word[bus.err_pos - 4'd1];
  end

  // ready_ok_reg keeps READY low during reset and releases it on the first clock edge.
  assign ready     = ready_ok_reg && (state_reg == IDLE) && device_en;
  assign bus.ready = ready;
  assign transfer  = bus.valid && ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      ready_ok_reg   <= 1'b0;
      tx_active_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      ready_ok_reg   <= 1'b1;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (transfer) begin
            shift_reg     <= code_word;
            bit_cnt_reg   <= 4'd0;
            tx_active_reg <= 1'b1;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[13:0], 1'b0};
          if (bit_cnt_reg == 4'd14) begin
            tx_active_reg <= 1'b0;
            if (FRAME_GAP == 0) begin
              state_reg <= IDLE;
            end else begin
              state_reg   <= GAP;
              gap_cnt_reg <= 2'(FRAME_GAP - 1);
            end
          end else begin
            bit_cnt_reg    <= bit_cnt_reg + 4'd1;
            frame_done_reg <= (bit_cnt_reg == 4'd13);
          end
        end
        GAP: begin
          if (gap_cnt_reg == 2'd0)
            state_reg <= IDLE;
          else
            gap_cnt_reg <= gap_cnt_reg - 2'd1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign serial_out = tx_active_reg ? shift_reg[14] : IDLE_LEVEL;
  assign tx_active  = tx_active_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: doc/hamming_encoder_tx.md
HAMMING_ENCODER_TX -- requirements
Module: hamming_encoder_tx

Interface
REQ-001 Parameter IDLE_LEVEL, default 1'b0: value driven on SERIAL_OUT whenever no frame is being shifted.
REQ-002 Parameter FRAME_GAP, default 1: number of idle cycles (0..3) after each frame before READY reasserts.
REQ-003 CLK  input  1: single clock, rising edge; all state is clocked on it.
REQ-004 REST  input  1: reset, asynchronous, active-high.
REQ-005 DEVICE_EN  input  1: block enable, gating new frame acceptance only.
REQ-006 DATA_IN  input  11: data word d[10:0].
REQ-007 VALID  input  1: DATA_IN valid request.
REQ-008 ERR_POS  input  4: test error injection; 0 = none, 1..15 = codeword position to invert; sampled with DATA_IN.
REQ-009 READY  output  1: block can accept a word this cycle.
REQ-010 SERIAL_OUT  output  1: serial codeword bit stream toward the decoder datapath.
REQ-011 TX_ACTIVE  output  1: high on every cycle SERIAL_OUT carries a codeword bit.
REQ-012 FRAME_DONE  output  1: one-cycle pulse on the cycle the last codeword bit is driven.

Function
REQ-013 Encoding SHALL be Hamming(15,11), even parity; codeword positions 1..15 map to codeword[0..14].
REQ-014 Data mapping SHALL be d0..d10 -> positions 3,5,6,7,9,10,11,12,13,14,15; parity bits at positions 1,2,4,8.
REQ-015 Parity at position p SHALL be the XOR of all data positions whose index has bit p set.
REQ-016 When ERR_POS is nonzero, the captured codeword SHALL have the bit at position ERR_POS inverted after parity generation.
REQ-017 FSM states SHALL be IDLE, SHIFT and GAP.
REQ-018 In IDLE, READY SHALL equal DEVICE_EN; TX_ACTIVE SHALL be 0; SERIAL_OUT SHALL be IDLE_LEVEL.
REQ-019 A transfer SHALL occur on a rising edge with VALID=1 and READY=1.
REQ-020 On a transfer: encoded codeword loads the 15-bit shift register, the 4-bit bit counter clears to 0, and the FSM enters SHIFT.
REQ-021 In SHIFT, SERIAL_OUT SHALL be codeword[14] (position 15), transmitted first and MSB-first.
- Shift register shifts left by one per cycle; bit counter increments per cycle.
- TX_ACTIVE=1 and READY=0 throughout SHIFT.
REQ-022 Timing: the first bit SHALL appear in the cycle after the transfer edge; exactly 15 SHIFT cycles per frame.
REQ-023 FRAME_DONE SHALL be 1 only in the SHIFT cycle with bit counter = 14.
REQ-024 After SHIFT, the FSM SHALL enter GAP for FRAME_GAP cycles, then IDLE.
- With FRAME_GAP=0, it goes directly to IDLE.
- GAP outputs are identical to IDLE except READY=0.
REQ-025 Throughput SHALL be one word per 15+FRAME_GAP+1 cycles when VALID is held high.
REQ-026 DEVICE_EN deasserted mid-frame SHALL NOT abort the frame; it only blocks the next transfer.
REQ-027 VALID without READY SHALL be ignored; DATA_IN and ERR_POS are not sampled.
REQ-028 DATA_IN and ERR_POS changes during SHIFT SHALL NOT affect the frame in flight.
REQ-029 The bit counter SHALL never exceed 14; it does not wrap inside a frame.

Reset
REQ-030 While REST=1, regardless of CLK, the block SHALL hold:
- state IDLE
- shift register and counter 0
- READY=0, SERIAL_OUT=IDLE_LEVEL, TX_ACTIVE=0, FRAME_DONE=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; no further frame bits are emitted.
REQ-032 After REST deasserts, READY SHALL follow DEVICE_EN from the first clock edge.

Verification
REQ-033 DATA_IN=11'h000, ERR_POS=0 -> SERIAL_OUT emits 15 zeros; FRAME_DONE pulses on the 15th bit.
REQ-034 DATA_IN=11'h7FF, ERR_POS=0 -> codeword 15'h7FFF; SERIAL_OUT emits 15 ones; TX_ACTIVE high for exactly 15 cycles.
REQ-035 DATA_IN=11'h001 -> codeword 15'h0007; serial order is twelve 0s then 1,1,1.
REQ-036 DATA_IN=11'h000, ERR_POS=5 -> codeword 15'h0010; serial order: ten 0s, one 1, four 0s.
REQ-037 VALID held high, FRAME_GAP=1, two words -> second frame's first bit appears 17 cycles after the first frame's first bit.
REQ-038 REST pulsed at bit 7 of a frame -> SERIAL_OUT=IDLE_LEVEL and TX_ACTIVE=0 immediately; READY=1 after release with DEVICE_EN=1.
